// File: rtl/ram_arbiter_if.sv
// Requester and RAM-side signals of ram_arbiter bundled into one interface.
// master = requesters + RAM model side, slave = the arbiter.
interface ram_arbiter_if #(
  parameter int ADDR_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic [7:0]        cpu_rdata;
  logic              cpu_ack;
  logic              cpu_wait;
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [7:0]        host_wdata;
  logic [7:0]        host_rdata;
  logic              host_ack;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;
  logic              ram_rd;
  logic              ram_wr;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_wait,
    output host_req, host_we, host_addr, host_wdata,
    input  host_rdata, host_ack,
    input  ram_addr, ram_dout, ram_rd, ram_wr,
    output ram_din
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_wait,
    input  host_req, host_we, host_addr, host_wdata,
    output host_rdata, host_ack,
    output ram_addr, ram_dout, ram_rd, ram_wr,
    input  ram_din
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester (CPU, host) arbiter for a single RAM port, fixed-latency reads.
// Optional RAM_ARB_ROM_PROTECT_EN: suppress ram_wr for CPU writes to the lower half.
module ram_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int RD_LATENCY = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic         sys_clock,
  input  logic         reset_n,
  ram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [2:0] LAT_LAST = 3'(RD_LATENCY - 1);
  localparam logic [3:0] SMAX     = 4'(STARVE_MAX);

  state_t            r_state, w_next;
  logic              r_cpu_arm, r_host_arm, r_gnt_host, r_block;
  logic [2:0]        r_lat;
  logic [3:0]        r_starve;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_dout, r_cpu_rdata, r_host_rdata;

  logic              w_cpu_armed, w_host_armed, w_gnt_host, w_grant, w_we, w_last;
  logic              w_block, w_cpu_ack, w_host_ack;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_wdata;

  assign w_cpu_armed  = bus.cpu_req & r_cpu_arm;
  assign w_host_armed = bus.host_req & r_host_arm;
  assign w_gnt_host   = w_host_armed & (~w_cpu_armed | (r_starve == SMAX));
  assign w_grant      = (r_state == IDLE) & (w_cpu_armed | w_host_armed);
  assign w_we         = w_gnt_host ? bus.host_we    : bus.cpu_we;
  assign w_addr       = w_gnt_host ? bus.host_addr  : bus.cpu_addr;
  assign w_wdata      = w_gnt_host ? bus.host_wdata : bus.cpu_wdata;
  assign w_last       = (r_lat == LAT_LAST);
  assign w_cpu_ack    = (r_state == DONE) & ~r_gnt_host;
  assign w_host_ack   = (r_state == DONE) & r_gnt_host;

`ifdef RAM_ARB_ROM_PROTECT_EN
  assign w_block = ~w_gnt_host & w_we & ~w_addr[ADDR_W-1];
`else
  assign w_block = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_next = w_we ? WRITE : READ;
      READ:    if (w_last)  w_next = DONE;
      WRITE:   w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Latched request: later changes on the granted port are ignored.
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_gnt_host   <= 1'b0;
      r_block      <= 1'b0;
      r_addr       <= '0;
      r_dout       <= '0;
      r_lat        <= '0;
      r_cpu_rdata  <= '0;
      r_host_rdata <= '0;
    end else if (w_grant) begin
      r_gnt_host <= w_gnt_host;
      r_block    <= w_block;
      r_addr     <= w_addr;
      r_dout     <= w_wdata;
      r_lat      <= '0;
    end else if (r_state == READ) begin
      r_lat <= r_lat + 3'd1;
      if (w_last) begin
        if (r_gnt_host) r_host_rdata <= bus.ram_din;
        else            r_cpu_rdata  <= bus.ram_din;
      end
    end
  end

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n)                          r_starve <= '0;
    else if (!w_host_armed)                r_starve <= '0;
    else if (w_grant && w_gnt_host)        r_starve <= '0;
    else if (w_grant && r_starve != SMAX)  r_starve <= r_starve + 4'd1;
  end

  // A low req re-arms even in the ack cycle, so a requester that drops
  // req for just that cycle can be granted again immediately.
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cpu_arm  <= 1'b1;
      r_host_arm <= 1'b1;
    end else begin
      if (!bus.cpu_req)     r_cpu_arm  <= 1'b1;
      else if (w_cpu_ack)   r_cpu_arm  <= 1'b0;
      if (!bus.host_req)    r_host_arm <= 1'b1;
      else if (w_host_ack)  r_host_arm <= 1'b0;
    end
  end

  assign bus.ram_addr   = r_addr;
  assign bus.ram_dout   = r_dout;
  assign bus.ram_rd     = (r_state == READ);
  assign bus.ram_wr     = (r_state == WRITE) & ~r_block;
  assign bus.cpu_ack    = w_cpu_ack;
  assign bus.host_ack   = w_host_ack;
  assign bus.cpu_rdata  = r_cpu_rdata;
  assign bus.host_rdata = r_host_rdata;
  assign bus.cpu_wait   = bus.cpu_req & r_cpu_arm & ~w_cpu_ack;
endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: drivers push expected acks/RAM writes,
// monitors pop and compare when the DUT presents them.
module tb_ram_arbiter;
  localparam int RDL = 2;
`ifdef RAM_ARB_ROM_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  typedef struct { bit host; bit rd; logic [7:0] data; } ack_t;
  typedef struct { logic [15:0] addr; logic [7:0] data; } wr_t;

  logic sys_clock = 1'b0;
  logic reset_n   = 1'b0;
  ram_arbiter_if #(.ADDR_W(16)) bus();
  ram_arbiter #(.ADDR_W(16), .RD_LATENCY(RDL), .STARVE_MAX(4)) dut (
    .sys_clock(sys_clock), .reset_n(reset_n), .bus(bus));

  always #5 sys_clock = ~sys_clock;

  logic [7:0] mem [0:65535];
  assign bus.ram_din = mem[bus.ram_addr];
  always @(posedge sys_clock) if (bus.ram_wr) mem[bus.ram_addr] = bus.ram_dout;

  int n_chk = 0, n_pass = 0, rd_runs = 0, wr_cnt = 0, run = 0;
  ack_t ack_q[$];
  wr_t  wr_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic push_ack(input bit host, input bit rd, input logic [7:0] d);
    ack_t e; e.host = host; e.rd = rd; e.data = d; ack_q.push_back(e);
  endtask

  task automatic push_wr(input logic [15:0] a, input logic [7:0] d);
    wr_t w; w.addr = a; w.data = d; wr_q.push_back(w);
  endtask

  // Ack monitor
  always @(negedge sys_clock) begin
    if (bus.cpu_ack || bus.host_ack) begin
      chk("ack_one_hot", {31'd0, bus.cpu_ack & bus.host_ack}, 0);
      if (ack_q.size() == 0) chk("ack_unexpected", 1, 0);
      else begin
        ack_t e;
        e = ack_q.pop_front();
        chk("ack_port", {31'd0, bus.host_ack}, {31'd0, e.host});
        if (e.rd) chk("rdata", {24'd0, e.host ? bus.host_rdata : bus.cpu_rdata}, {24'd0, e.data});
        if (bus.cpu_ack) chk("cpu_wait_at_ack", {31'd0, bus.cpu_wait}, 0);
      end
    end
  end

  // RAM-side monitor
  always @(negedge sys_clock) begin
    if (!reset_n) run = 0;
    else begin
      if (bus.ram_rd && bus.ram_wr) chk("rd_wr_overlap", 1, 0);
      if (bus.ram_rd) run++;
      else if (run != 0) begin
        chk("rd_len", run, RDL);
        rd_runs++;
        run = 0;
      end
      if (bus.ram_wr) begin
        wr_cnt++;
        if (wr_q.size() == 0) chk("wr_unexpected", {16'd0, bus.ram_addr}, 32'hFFFF_FFFF);
        else begin
          wr_t w;
          w = wr_q.pop_front();
          chk("wr_addr", {16'd0, bus.ram_addr}, {16'd0, w.addr});
          chk("wr_data", {24'd0, bus.ram_dout}, {24'd0, w.data});
        end
      end
    end
  end

  // Drive one access, wait (bounded) for its ack, drop req in the ack cycle.
  task automatic drive(input bit host, input bit we, input logic [15:0] a, input logic [7:0] d);
    bit got = 0;
    if (host) begin bus.host_we = we; bus.host_addr = a; bus.host_wdata = d; bus.host_req = 1'b1; end
    else      begin bus.cpu_we  = we; bus.cpu_addr  = a; bus.cpu_wdata  = d; bus.cpu_req  = 1'b1; end
    for (int i = 0; i < 60; i++) begin
      @(negedge sys_clock);
      if (host ? bus.host_ack : bus.cpu_ack) begin got = 1; break; end
    end
    if (!got) chk(host ? "host_timeout" : "cpu_timeout", 0, 1);
    if (host) bus.host_req = 1'b0; else bus.cpu_req = 1'b0;
    @(posedge sys_clock); #1;
  endtask

  // Expected RAM write for a write access, honouring ROM protection.
  task automatic exp_write(input bit host, input logic [15:0] a, input logic [7:0] d);
    push_ack(host, 0, 8'h00);
    if (!(PROT && !host && !a[15])) push_wr(a, d);
  endtask

  initial begin
    int cyc, runs0, wr0;
    bit got;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 8; i++) mem[16'h8000 + i] = 8'hA5 + 8'(i);
    mem[16'h0200] = 8'h11;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.host_req = 0; bus.host_we = 0; bus.host_addr = 0; bus.host_wdata = 0;

    // Reset state
    #1;
    chk("rst_ram_rd", {31'd0, bus.ram_rd}, 0);
    chk("rst_ram_wr", {31'd0, bus.ram_wr}, 0);
    chk("rst_acks", {30'd0, bus.cpu_ack, bus.host_ack}, 0);
    chk("rst_ram_addr", {16'd0, bus.ram_addr}, 0);
    chk("rst_ram_dout", {24'd0, bus.ram_dout}, 0);
    chk("rst_rdata", {16'd0, bus.cpu_rdata, bus.host_rdata}, 0);
    repeat (2) @(negedge sys_clock);
    reset_n = 1'b1;
    @(posedge sys_clock); #1;

    // CPU read 8000 -> A5, latency and wait checks
    push_ack(0, 1, 8'hA5);
    bus.cpu_we = 0; bus.cpu_addr = 16'h8000; bus.cpu_req = 1;
    #1 chk("cpu_wait_pending", {31'd0, bus.cpu_wait}, 1);
    cyc = 0; got = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge sys_clock); #1; cyc++;
      if (bus.cpu_ack) begin got = 1; break; end
    end
    chk("cpu_rd_latency", got ? cyc : -1, RDL + 1);
    bus.cpu_req = 0;
    @(posedge sys_clock); #1;

    // Host write then host read back
    exp_write(1, 16'h0100, 8'h3C);
    drive(1, 1, 16'h0100, 8'h3C);
    push_ack(1, 1, 8'h3C);
    drive(1, 0, 16'h0100, 8'h00);

    // Starvation: 4 CPU grants, then host, then CPU again
    for (int i = 0; i < 4; i++) push_ack(0, 1, 8'hA5 + 8'(i));
    push_ack(1, 1, 8'h11);
    push_ack(0, 1, 8'hA9);
    push_ack(0, 1, 8'hAA);
    fork
      begin for (int i = 0; i < 6; i++) drive(0, 0, 16'h8000 + 16'(i), 8'h00); end
      drive(1, 0, 16'h0200, 8'h00);
    join

    // Held request: only one access until req drops
    runs0 = rd_runs;
    push_ack(0, 1, 8'hA7);
    bus.cpu_we = 0; bus.cpu_addr = 16'h8002; bus.cpu_req = 1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clock);
      if (bus.cpu_ack) begin got = 1; break; end
    end
    if (!got) chk("held_timeout", 0, 1);
    repeat (10) @(posedge sys_clock);
    #1 chk("held_one_access", rd_runs - runs0, 1);
    bus.cpu_req = 0;
    @(posedge sys_clock); #1;
    push_ack(0, 1, 8'hA7);
    drive(0, 0, 16'h8002, 8'h00);
    chk("held_rearm_access", rd_runs - runs0, 2);

    // Reset mid-read: abort, then served fresh
    push_ack(0, 1, 8'hA8);
    bus.cpu_we = 0; bus.cpu_addr = 16'h8003; bus.cpu_req = 1;
    @(posedge sys_clock); #2;
    reset_n = 1'b0;
    #1;
    chk("abort_ram_rd", {31'd0, bus.ram_rd}, 0);
    chk("abort_no_ack", {31'd0, bus.cpu_ack}, 0);
    repeat (2) @(negedge sys_clock);
    reset_n = 1'b1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clock);
      if (bus.cpu_ack) begin got = 1; break; end
    end
    chk("abort_reserved", {31'd0, got}, 1);
    bus.cpu_req = 0;
    @(posedge sys_clock); #1;

    // CPU writes: ROM area (protected when enabled) and upper half
    wr0 = wr_cnt;
    exp_write(0, 16'h1234, 8'hAA);
    drive(0, 1, 16'h1234, 8'hAA);
    chk("rom_area_writes", wr_cnt - wr0, PROT ? 0 : 1);
    wr0 = wr_cnt;
    exp_write(0, 16'h9000, 8'hBB);
    drive(0, 1, 16'h9000, 8'hBB);
    chk("ram_area_writes", wr_cnt - wr0, 1);
    push_ack(0, 1, 8'hBB);
    drive(0, 0, 16'h9000, 8'h00);

    repeat (4) @(posedge sys_clock);
    chk("ack_q_drained", ack_q.size(), 0);
    chk("wr_q_drained", wr_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
